// File: rtl/shift_pkg.sv
// Shared definitions for the shift sequencer: shift-type codes, FSM state
// encodings, default widths and the effective-amount helper.
package shift_pkg;

    localparam logic [1:0] SHIFT_LSL = 2'b00;
    localparam logic [1:0] SHIFT_LSR = 2'b01;
    localparam logic [1:0] SHIFT_ASR = 2'b10;
    localparam logic [1:0] SHIFT_ROR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int MAX_STEP_DEF   = 15;

    // Effective shift distance: LSL/LSR saturate at 33 (anything beyond 32
    // gives the same result and carry), ASR saturates at 32, ROR is modulo 32.
    function automatic logic [5:0] eff_amount(input logic [1:0] t, input logic [7:0] a);
        logic [5:0] n;
        n = 6'd0;
        case (t)
            SHIFT_LSL, SHIFT_LSR: n = (a > 8'd33) ? 6'd33 : a[5:0];
            SHIFT_ASR:            n = (a > 8'd32) ? 6'd32 : a[5:0];
            default:              n = {1'b0, a[4:0]};
        endcase
        return n;
    endfunction

endpackage

// File: rtl/shift_step_unit.sv
// Combinational single pass of the shift sequencer: shifts data by a 0..15
// step according to the shift type and reports the last bit shifted out.
module shift_step_unit
    import shift_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [1:0]            type_i,
    input  logic [3:0]            step_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  carry_o
);

    logic [2*DATA_WIDTH-1:0] rot_w;

    // One pass: widened shifts expose the last bit shifted out at the edge.
    always_comb begin
        data_o  = data_i;
        carry_o = 1'b0;
        rot_w   = {data_i, data_i} >> step_i;
        case (type_i)
            SHIFT_LSL: {carry_o, data_o} = {1'b0, data_i} << step_i;
            SHIFT_LSR: {data_o, carry_o} = {data_i, 1'b0} >> step_i;
            SHIFT_ASR: {data_o, carry_o} = $signed({data_i, 1'b0}) >>> step_i;
            default: begin
                data_o  = rot_w[DATA_WIDTH-1:0];
                carry_o = rot_w[DATA_WIDTH-1];
            end
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle register-specified shift controller (ARM semantics). Large
// amounts are split into passes of at most MAX_STEP bits.
// Optional macro SHIFT_SEQ_FLUSH_EN adds a flush input that aborts any
// in-flight operation and returns the sequencer to IDLE.
//
// Handshake: a request is taken on a rising edge where req_valid and
// req_ready are both high; a response is consumed on a rising edge where
// resp_valid and resp_ready are both high. resp_data/resp_carry stay stable
// while resp_valid is high and not yet consumed.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int MAX_STEP   = MAX_STEP_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [DATA_WIDTH-1:0] req_data,
    input  logic [1:0]            req_type,
    input  logic [7:0]            req_amount,
    input  logic                  req_carry,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_carry,
`ifdef SHIFT_SEQ_FLUSH_EN
    input  logic                  flush,
`endif
    output logic [1:0]            dbg_state
);

    localparam logic [3:0] MAX_STEP4 = 4'(MAX_STEP);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [1:0]            type_q, type_d;
    logic                  carry_q, carry_d;
    logic [5:0]            remaining_q, remaining_d;
    logic                  resp_valid_q, resp_valid_d;

    logic [3:0]            step_w;
    logic [DATA_WIDTH-1:0] step_data_w;
    logic                  step_carry_w;
    logic [5:0]            eff_w;
    logic                  flush_w;

`ifdef SHIFT_SEQ_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    assign eff_w  = eff_amount(req_type, req_amount);
    assign step_w = (remaining_q >= {2'b00, MAX_STEP4}) ? MAX_STEP4 : remaining_q[3:0];

    shift_step_unit #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_step (
        .data_i  (data_q),
        .type_i  (type_q),
        .step_i  (step_w),
        .data_o  (step_data_w),
        .carry_o (step_carry_w)
    );

    assign req_ready  = (state_q == ST_IDLE) && !flush_w;
    assign resp_valid = resp_valid_q;
    assign resp_data  = data_q;
    assign resp_carry = carry_q;
    assign dbg_state  = state_q;

    // Next-state logic: accept and classify in IDLE, one pass per SHIFT cycle,
    // raise resp_valid one cycle after entering DONE and wait for the consumer.
    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        type_d       = type_q;
        carry_d      = carry_q;
        remaining_d  = remaining_q;
        resp_valid_d = resp_valid_q;
        if (flush_w) begin
            state_d      = ST_IDLE;
            resp_valid_d = 1'b0;
            remaining_d  = 6'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        data_d      = req_data;
                        type_d      = req_type;
                        carry_d     = req_carry;
                        remaining_d = eff_w;
                        if (req_type == SHIFT_ROR && req_amount != 8'd0 && req_amount[4:0] == 5'd0) begin
                            // Rotation by a non-zero multiple of 32: data unchanged, C = bit 31.
                            carry_d     = req_data[DATA_WIDTH-1];
                            remaining_d = 6'd0;
                            state_d     = ST_DONE;
                        end else if (eff_w == 6'd0) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    data_d      = step_data_w;
                    carry_d     = step_carry_w;
                    remaining_d = remaining_q - {2'b00, step_w};
                    if (remaining_d == 6'd0) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!resp_valid_q) begin
                        resp_valid_d = 1'b1;
                    end else if (resp_ready) begin
                        resp_valid_d = 1'b0;
                        state_d      = ST_IDLE;
                    end
                end
                default: begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b0;
                    remaining_d  = 6'd0;
                end
            endcase
        end
    end

    // State and datapath registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            data_q       <= '0;
            type_q       <= SHIFT_LSL;
            carry_q      <= 1'b0;
            remaining_q  <= 6'd0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            type_q       <= type_d;
            carry_q      <= carry_d;
            remaining_q  <= remaining_d;
            resp_valid_q <= resp_valid_d;
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed table-driven bench for shift_sequencer with hand-written
// sequences for backpressure, reset abort and (optionally) flush abort.
module tb_shift_sequencer;
    import shift_pkg::*;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  typ;
        logic [7:0]  amt;
        logic        cin;
        logic [31:0] exp_d;
        logic        exp_c;
        int          exp_lat;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_data;
    logic [1:0]  req_type;
    logic [7:0]  req_amount;
    logic        req_carry;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_carry;
    logic [1:0]  dbg_state;
`ifdef SHIFT_SEQ_FLUSH_EN
    logic        flush;
`endif

    int checks   = 0;
    int failures = 0;

    vec_t vecs[15];

    shift_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .req_type   (req_type),
        .req_amount (req_amount),
        .req_carry  (req_carry),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_carry (resp_carry),
`ifdef SHIFT_SEQ_FLUSH_EN
        .flush      (flush),
`endif
        .dbg_state  (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Run one request from an idle negedge through to the consumed response.
    task automatic do_op(input vec_t v, input string tag);
        int lat;
        bit got;
        check({tag, " req_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_data   = v.data;
        req_type   = v.typ;
        req_amount = v.amt;
        req_carry  = v.cin;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_data   = ~v.data;
        req_type   = ~v.typ;
        req_amount = 8'($urandom_range(0, 255));
        req_carry  = ~v.cin;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 16) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (resp_valid) got = 1'b1;
        end
        check({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
        check({tag, " data"}, resp_data, v.exp_d);
        check({tag, " carry"}, {31'd0, resp_carry}, {31'd0, v.exp_c});
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        @(negedge clk);
        check({tag, " valid cleared"}, {31'd0, resp_valid}, 32'd0);
        check({tag, " back to idle"}, {30'd0, dbg_state}, {30'd0, ST_IDLE});
    endtask

    initial begin
        int bad;
        vec_t v;
        // data, type, amount, carry_in, exp data, exp carry, latency
        vecs[0]  = '{32'h0000_0001, SHIFT_LSL, 8'd20,  1'b0, 32'h0010_0000, 1'b0, 3};
        vecs[1]  = '{32'h8000_0000, SHIFT_ASR, 8'd200, 1'b0, 32'hFFFF_FFFF, 1'b1, 4};
        vecs[2]  = '{32'h8000_0001, SHIFT_LSR, 8'd32,  1'b0, 32'h0000_0000, 1'b1, 4};
        vecs[3]  = '{32'h8000_0001, SHIFT_LSR, 8'd33,  1'b1, 32'h0000_0000, 1'b0, 4};
        vecs[4]  = '{32'h0000_0001, SHIFT_LSL, 8'd32,  1'b0, 32'h0000_0000, 1'b1, 4};
        vecs[5]  = '{32'h1234_5678, SHIFT_ROR, 8'd0,   1'b1, 32'h1234_5678, 1'b1, 1};
        vecs[6]  = '{32'h1234_5678, SHIFT_ROR, 8'd64,  1'b1, 32'h1234_5678, 1'b0, 1};
        vecs[7]  = '{32'h1234_5678, SHIFT_ROR, 8'd4,   1'b0, 32'h8123_4567, 1'b1, 2};
        vecs[8]  = '{32'hFFFF_FFFF, SHIFT_LSL, 8'd0,   1'b0, 32'hFFFF_FFFF, 1'b0, 1};
        vecs[9]  = '{32'h8000_0000, SHIFT_LSR, 8'd15,  1'b1, 32'h0001_0000, 1'b0, 2};
        vecs[10] = '{32'h8000_0000, SHIFT_ASR, 8'd16,  1'b1, 32'hFFFF_8000, 1'b0, 3};
        vecs[11] = '{32'h0000_0001, SHIFT_ROR, 8'd33,  1'b0, 32'h8000_0000, 1'b1, 2};
        vecs[12] = '{32'h7FFF_FFFF, SHIFT_ASR, 8'd40,  1'b1, 32'h0000_0000, 1'b0, 4};
        vecs[13] = '{32'h0000_000F, SHIFT_LSL, 8'd30,  1'b0, 32'hC000_0000, 1'b1, 3};
        vecs[14] = '{32'hF000_0000, SHIFT_LSR, 8'd255, 1'b1, 32'h0000_0000, 1'b0, 4};

        // Reset block
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_data   = '0;
        req_type   = SHIFT_LSL;
        req_amount = '0;
        req_carry  = 1'b0;
        resp_ready = 1'b0;
`ifdef SHIFT_SEQ_FLUSH_EN
        flush      = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("reset state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        check("reset resp_valid", {31'd0, resp_valid}, 32'd0);
        check("reset resp_data", resp_data, 32'd0);
        check("reset resp_carry", {31'd0, resp_carry}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Table-driven vectors
        for (int i = 0; i < 15; i++) begin
            do_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: LSL 1 by 4 held for 5 cycles with a competing request
        req_valid  = 1'b1;
        req_data   = 32'h0000_0001;
        req_type   = SHIFT_LSL;
        req_amount = 8'd4;
        req_carry  = 1'b1;
        @(posedge clk);
        #1;
        req_data   = 32'h0000_0108;
        req_type   = SHIFT_LSR;
        req_amount = 8'd4;
        req_carry  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("bp valid", {31'd0, resp_valid}, 32'd1);
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (resp_valid !== 1'b1 || resp_data !== 32'h0000_0010 || resp_carry !== 1'b0 ||
                req_ready !== 1'b0 || dbg_state !== ST_DONE) bad++;
        end
        check("bp hold stable", 32'(bad), 32'd0);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        @(negedge clk);
        check("bp idle after handshake", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        check("bp req_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("bp next accepted", {30'd0, dbg_state}, {30'd0, ST_SHIFT});
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("bp next valid", {31'd0, resp_valid}, 32'd1);
        check("bp next data", resp_data, 32'h0000_0010);
        check("bp next carry", {31'd0, resp_carry}, 32'd1);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        @(negedge clk);

        // Reset abort in the second SHIFT cycle of LSL by 40
        req_valid  = 1'b1;
        req_data   = 32'h0000_0001;
        req_type   = SHIFT_LSL;
        req_amount = 8'd40;
        req_carry  = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst mid shift state", {30'd0, dbg_state}, {30'd0, ST_SHIFT});
        reset = 1'b1;
        #1;
        check("rst abort state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        check("rst abort valid", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst release ready", {31'd0, req_ready}, 32'd1);
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0) bad++;
        end
        check("rst no resp pulse", 32'(bad), 32'd0);
        v = '{32'h0000_0001, SHIFT_LSL, 8'd40, 1'b0, 32'h0000_0000, 1'b0, 4};
        do_op(v, "rst recovery");

`ifdef SHIFT_SEQ_FLUSH_EN
        // Flush abort in the second SHIFT cycle of LSL by 40
        req_valid  = 1'b1;
        req_data   = 32'h0000_0001;
        req_type   = SHIFT_LSL;
        req_amount = 8'd40;
        req_carry  = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("fl mid shift state", {30'd0, dbg_state}, {30'd0, ST_SHIFT});
        flush = 1'b1;
        #1;
        check("fl req_ready low", {31'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("fl abort state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        check("fl ready after", {31'd0, req_ready}, 32'd1);
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0) bad++;
        end
        check("fl no resp pulse", 32'(bad), 32'd0);
        do_op(v, "fl recovery");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
